// File: rtl/fc_pkg.sv
// Shared types for the FC stream loader: FSM states, phase-flag encoding, data width.
package fc_pkg;

    localparam int FC_DATA_W = 16;

    typedef enum logic [3:0] {
        IDLE,
        LD_W1,
        LD_W2,
        LD_ANS,
        LD_IN,
        RUN,
        BP,
        BATCH,
        WAIT_BATCH
    } fc_state_t;

    // {weight1, weight2, right_answer}
    typedef logic [2:0] fc_phase_t;

    localparam fc_phase_t PH_NONE = 3'b000;
    localparam fc_phase_t PH_W1   = 3'b100;
    localparam fc_phase_t PH_W2   = 3'b010;
    localparam fc_phase_t PH_ANS  = 3'b001;

    function automatic fc_phase_t phase_of(input fc_state_t s);
        case (s)
            LD_W1:   phase_of = PH_W1;
            LD_W2:   phase_of = PH_W2;
            LD_ANS:  phase_of = PH_ANS;
            default: phase_of = PH_NONE;
        endcase
    endfunction

    function automatic logic is_load(input fc_state_t s);
        is_load = (s == LD_W1) || (s == LD_W2) ||
                  (s == LD_ANS) || (s == LD_IN);
    endfunction

endpackage

// File: rtl/fc_beat_counter.sv
// Loadable up-counter with clear and terminal-count flag.
// Clear has priority over load, load over increment.
module fc_beat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         tc
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc) begin
            count <= count + W'(1);
        end
    end

    assign tc = (count == limit);

endmodule

// File: rtl/fc_stream_loader.sv
// Transmit-side sequencer feeding the FC top from a 16-bit valid/ready stream.
// Optional back-propagation handshake compiled in with FC_BCK_PROP_EN.
module fc_stream_loader
    import fc_pkg::*;
#(
    parameter int FRT_CELL   = 14,
    parameter int MID_CELL   = 10,
    parameter int BCK_CELL   = 5,
    parameter int BATCH_SIZE = 32
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          cmd_start,
    input  logic                          cmd_weights,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [15:0]                   s_data,
    output logic                          ex_we,
    output logic [15:0]                   ex_value,
    output logic [15:0]                   ex_addr,
    output logic                          weight1,
    output logic                          weight2,
    output logic                          right_answer,
    output logic                          enable,
    input  logic                          all_end,
    output logic                          bck_prop_start,
    input  logic                          fc_bck_prop_end,
    output logic                          batch_end,
    input  logic                          fc_batch_end,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(BATCH_SIZE):0]   sample_cnt
);

    localparam int LEN_W1  = FRT_CELL * MID_CELL;
    localparam int LEN_W2  = MID_CELL * BCK_CELL;
    localparam int LEN_ANS = BCK_CELL;
    localparam int LEN_IN  = FRT_CELL;

    localparam int MAX_A   = (LEN_W1 > LEN_W2) ? LEN_W1 : LEN_W2;
    localparam int MAX_B   = (LEN_ANS > LEN_IN) ? LEN_ANS : LEN_IN;
    localparam int MAX_LEN = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int BEAT_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int CNT_W   = $clog2(BATCH_SIZE) + 1;

    fc_state_t state_q;
    fc_state_t state_d;

    logic              load_st;
    logic              accept;
    logic              beat_tc;
    logic              beat_last;
    logic [BEAT_W-1:0] beat;
    logic [BEAT_W-1:0] beat_lim;
    logic              run_fin;
    logic              smp_done;
    logic              smp_tc;
    logic              smp_clr;
    fc_phase_t         phase_q;

    assign load_st   = is_load(state_q);
    assign accept    = load_st & s_valid;
    assign beat_last = accept & beat_tc;
    assign run_fin   = (state_q == RUN) & enable & all_end;
    assign smp_clr   = (state_q == IDLE) & cmd_start;

`ifdef FC_BCK_PROP_EN
    assign smp_done = (state_q == BP) & fc_bck_prop_end;
`else
    assign smp_done = run_fin;
`endif

    always_comb begin
        beat_lim = BEAT_W'(LEN_IN - 1);
        case (state_q)
            LD_W1:   beat_lim = BEAT_W'(LEN_W1 - 1);
            LD_W2:   beat_lim = BEAT_W'(LEN_W2 - 1);
            LD_ANS:  beat_lim = BEAT_W'(LEN_ANS - 1);
            default: beat_lim = BEAT_W'(LEN_IN - 1);
        endcase
    end

    // Beat counter restarts whenever a phase ends or no load is active.
    fc_beat_counter #(
        .W(BEAT_W)
    ) u_beat (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (!load_st | beat_last),
        .load     (1'b0),
        .load_val ('0),
        .inc      (accept),
        .limit    (beat_lim),
        .count    (beat),
        .tc       (beat_tc)
    );

    fc_beat_counter #(
        .W(CNT_W)
    ) u_sample (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (smp_clr),
        .load     (1'b0),
        .load_val ('0),
        .inc      (smp_done),
        .limit    (CNT_W'(BATCH_SIZE - 1)),
        .count    (sample_cnt),
        .tc       (smp_tc)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_start) begin
                    state_d = cmd_weights ? LD_W1 : LD_ANS;
                end
            end
            LD_W1: begin
                if (beat_last) state_d = LD_W2;
            end
            LD_W2: begin
                if (beat_last) state_d = LD_ANS;
            end
            LD_ANS: begin
                if (beat_last) state_d = LD_IN;
            end
            LD_IN: begin
                if (beat_last) state_d = RUN;
            end
            RUN: begin
`ifdef FC_BCK_PROP_EN
                if (run_fin) state_d = BP;
`else
                if (run_fin) state_d = smp_tc ? BATCH : LD_ANS;
`endif
            end
            BP: begin
`ifdef FC_BCK_PROP_EN
                if (fc_bck_prop_end) state_d = smp_tc ? BATCH : LD_ANS;
`else
                state_d = IDLE;
`endif
            end
            BATCH: begin
                state_d = WAIT_BATCH;
            end
            WAIT_BATCH: begin
                if (fc_batch_end) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Write port and flags describe the word accepted on the previous edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ex_we     <= 1'b0;
            ex_value  <= '0;
            ex_addr   <= '0;
            phase_q   <= PH_NONE;
            enable    <= 1'b0;
            batch_end <= 1'b0;
            done      <= 1'b0;
        end else begin
            ex_we     <= accept;
            phase_q   <= accept ? phase_of(state_q) : PH_NONE;
            enable    <= (state_q == RUN) & !run_fin;
            batch_end <= (state_d == BATCH);
            done      <= (state_q == WAIT_BATCH) & fc_batch_end;
            if (accept) begin
                ex_value <= s_data;
                ex_addr  <= FC_DATA_W'(beat);
            end
        end
    end

`ifdef FC_BCK_PROP_EN
    logic bp_start_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bp_start_q <= 1'b0;
        end else begin
            bp_start_q <= (state_q == RUN) & (state_d == BP);
        end
    end

    assign bck_prop_start = bp_start_q;
`else
    logic unused_bp;

    assign unused_bp      = fc_bck_prop_end;
    assign bck_prop_start = 1'b0;
`endif

    assign s_ready      = load_st;
    assign busy         = (state_q != IDLE);
    assign weight1      = phase_q[2];
    assign weight2      = phase_q[1];
    assign right_answer = phase_q[0];

endmodule

// File: doc/fc_stream_loader.md
# fc_stream_loader

Transmit-side sequencer for the fully connected (FC) top. It accepts a 16-bit valid/ready word stream from upstream and drives the FC top's external write port (`ex_we`/`ex_value`/`ex_addr`). It also drives the phase flags (`weight1`, `weight2`, `right_answer`) and the run handshake (`enable`/`all_end`), then closes each mini-batch with `batch_end`/`fc_batch_end`. It sits between the flatten/host data source and the FC top, one instance per FC top.

## Interface
- `FRT_CELL`, 14, front-layer cell count (flatten input words per sample)
- `MID_CELL`, 10, middle-layer cell count
- `BCK_CELL`, 5, back-layer cell count (right-answer words per sample)
- `BATCH_SIZE`, 32, samples per mini-batch
- `clk`  in  1  sole clock, all logic on rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `cmd_start`  in  1  one-cycle pulse, starts a batch; ignored while `busy`=1
- `cmd_weights`  in  1  sampled with `cmd_start`; 1 = load weight1 and weight2 before the batch
- `s_valid`  in  1  upstream word valid
- `s_ready`  out  1  upstream word accepted when `s_valid & s_ready`
- `s_data`  in  16  upstream word
- `ex_we`, `ex_value[15:0]`, `ex_addr[15:0]`  out  external write to FC memory
- `weight1`, `weight2`, `right_answer`  out  1 each  phase flags, one-hot or all zero
- `enable`  out  1  FC forward run request
- `all_end`  in  1  FC forward run finished
- `bck_prop_start`  out  1  back-propagation start pulse
- `fc_bck_prop_end`  in  1  back-propagation finished
- `batch_end`  out  1  mini-batch finished pulse
- `fc_batch_end`  in  1  FC batch update finished
- `busy`  out  1  FSM not in IDLE
- `done`  out  1  one-cycle pulse after `fc_batch_end`
- `sample_cnt`  out  $clog2(BATCH_SIZE)+1  samples completed in the current batch

## Operation
- FSM states: IDLE, LD_W1, LD_W2, LD_ANS, LD_IN, RUN, BP, BATCH, WAIT_BATCH.
- IDLE, on `cmd_start`:
  - go to LD_W1 if `cmd_weights`=1, else LD_ANS.
  - clear `sample_cnt`.
- Load-phase lengths:
  - LD_W1: FRT_CELL*MID_CELL words.
  - LD_W2: MID_CELL*BCK_CELL words.
  - LD_ANS: BCK_CELL words.
  - LD_IN: FRT_CELL words.
- Per-word behaviour in load states:
  - `s_ready`=1 in every load state and 0 elsewhere.
  - Each accepted word writes address = beat counter. The counter restarts at 0 in each phase and is zero-extended to 16 bits.
  - On the last beat (counter = length-1), the FSM moves to the next state in the same edge:
    - LD_W1 → LD_W2
    - LD_W2 → LD_ANS
    - LD_ANS → LD_IN
    - LD_IN → RUN
- Phase flags are registered together with `ex_we` and belong to the word being written:
  - `weight1` for LD_W1, `weight2` for LD_W2, `right_answer` for LD_ANS, none for LD_IN.
  - Flags are 0 in every cycle where `ex_we`=0.
- RUN:
  - `enable` is held at 1 until `all_end` is sampled at 1; `enable` is 0 in the following cycle.
  - `ex_we` and all phase flags are 0 while `enable`=1.
  - After `all_end`, go to BP (if compiled in), else straight to sample completion.
- Sample completion:
  - `sample_cnt` increments by 1.
  - If `sample_cnt` (after the increment) = BATCH_SIZE, go to BATCH; else go to LD_ANS.
- BATCH: pulse `batch_end` for 1 cycle, then WAIT_BATCH.
- WAIT_BATCH: on `fc_batch_end`, pulse `done` and go to IDLE.
- `all_end`, `fc_bck_prop_end` and `fc_batch_end` are ignored outside their wait states.

## Timing
- Reset value of every output is 0; the FSM resets to IDLE and the counters clear.
- Reset mid-operation aborts immediately, with no drain.
- Write latency is 1: a word accepted at edge t appears on `ex_*` in the cycle after t.
- `s_valid`=0 in a load state gives `ex_we`=0 that cycle; the counter holds. There is no bubble between phases.
- If the last LD_IN word is accepted at edge t:
  - `ex_we`=1 in cycle t+1.
  - `enable`=1 from cycle t+2.
  - `ex_we` and `enable` are never 1 in the same cycle.
- `all_end` sampled 1 at edge u: `enable`=0 from cycle u+1.
- `batch_end`, `bck_prop_start` and `done` are single-cycle pulses.
- `cmd_start` while `busy`=1 has no effect.

## Configuration
- Macro: `FC_BCK_PROP_EN`.
- Defined:
  - after RUN, the BP state pulses `bck_prop_start` for one cycle.
  - the FSM then waits for `fc_bck_prop_end` before completing the sample.
- Undefined:
  - the BP state is absent; RUN goes directly to sample completion.
  - `bck_prop_start` is tied to 0 and `fc_bck_prop_end` is unused.

## Structure
- Shared package `fc_pkg` holds:
  - the FSM state typedef;
  - the phase-flag encoding constants;
  - `FC_DATA_W` = 16.
- Phase lengths are derived localparams inside the module.
- One sub-module: `fc_beat_counter`, a loadable up-counter with clear and a terminal-count flag. It is used for both the beat count and `sample_cnt`.

## Test plan
- Weights: `cmd_start` with `cmd_weights`=1, continuous `s_valid`.
  - Expect 140 writes with `weight1`=1 at addresses 0..139.
  - Then 50 writes with `weight2`=1 at addresses 0..49.
  - Then 5 writes with `right_answer`=1 and 14 writes with no flags.
  - `enable` rises 2 cycles after the last accept.
- Stall: toggle `s_valid` every other cycle during LD_IN.
  - Expect exactly 14 writes, addresses contiguous, no duplicates.
- Run handshake: return `all_end` 7 cycles after `enable` rises.
  - Expect `enable` low the next cycle and `s_ready` high for the next sample.
- Batch: run with BATCH_SIZE=2 and `cmd_weights`=0.
  - Expect exactly one `batch_end` pulse after the 2nd `all_end`.
  - `done` pulses 1 cycle after `fc_batch_end`.
- Reset: assert `reset_n`=0 in RUN.
  - Expect all outputs 0 at the next edge and state IDLE.
  - `cmd_start` then restarts cleanly.
- Macro: with `FC_BCK_PROP_EN` defined, expect a `bck_prop_start` pulse after each `all_end`, and no reload until `fc_bck_prop_end`.
